// File: rtl/lsu_pkg.sv
// lsu_pkg: shared definitions for the load/store unit.
//   SIZE_B/SIZE_H/SIZE_W : req_size encodings (2'b11 is illegal)
//   state_t              : control FSM states
//   is_bad_access        : flags misaligned or illegal-size requests
package lsu_pkg;

  localparam logic [1:0] SIZE_B = 2'b00;
  localparam logic [1:0] SIZE_H = 2'b01;
  localparam logic [1:0] SIZE_W = 2'b10;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    MERGE  = 2'd2
  } state_t;

  function automatic logic is_bad_access(input logic [1:0] size, input logic [1:0] off);
    logic bad;
    case (size)
      SIZE_B:  bad = 1'b0;
      SIZE_H:  bad = off[0];
      SIZE_W:  bad = |off;
      default: bad = 1'b1;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/lsu_align.sv
// lsu_align: combinational lane logic for the load/store unit.
//   i_size, i_unsigned, i_off : access size, zero-extend flag, byte offset
//   i_word                    : memory word (load source or merge base)
//   i_wdata                   : right-aligned store data
//   o_load                    : extracted and extended load data
//   o_merged                  : i_word with the addressed lanes replaced
module lsu_align
  import lsu_pkg::*;
(
  input  logic [1:0]  i_size,
  input  logic        i_unsigned,
  input  logic [1:0]  i_off,
  input  logic [31:0] i_word,
  input  logic [31:0] i_wdata,
  output logic [31:0] o_load,
  output logic [31:0] o_merged
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  always_comb begin
    w_byte = 8'd0;
    case (i_off)
      2'd0: w_byte = i_word[7:0];
      2'd1: w_byte = i_word[15:8];
      2'd2: w_byte = i_word[23:16];
      2'd3: w_byte = i_word[31:24];
      default: w_byte = 8'd0;
    endcase
    w_half = i_off[1] ? i_word[31:16] : i_word[15:0];

    case (i_size)
      SIZE_B:  o_load = {{24{~i_unsigned & w_byte[7]}}, w_byte};
      SIZE_H:  o_load = {{16{~i_unsigned & w_half[15]}}, w_half};
      default: o_load = i_word;
    endcase
  end

  // Little-endian lane replacement; a word store simply takes wdata.
  always_comb begin
    o_merged = i_word;
    case (i_size)
      SIZE_B: begin
        case (i_off)
          2'd0: o_merged[7:0]   = i_wdata[7:0];
          2'd1: o_merged[15:8]  = i_wdata[7:0];
          2'd2: o_merged[23:16] = i_wdata[7:0];
          2'd3: o_merged[31:24] = i_wdata[7:0];
          default: o_merged = i_word;
        endcase
      end
      SIZE_H: begin
        if (i_off[1]) o_merged[31:16] = i_wdata[15:0];
        else          o_merged[15:0]  = i_wdata[15:0];
      end
      default: o_merged = i_wdata;
    endcase
  end

endmodule

// File: rtl/lsu.sv
// lsu: single-outstanding load/store unit between a core and a word RAM
// with combinational read and synchronous write.
//   clk, rst                        : clock, synchronous active-high reset
//   req_valid/req_ready             : request handshake
//   req_we/size/unsigned/addr/wdata : request fields (byte address)
//   resp_valid/resp_rdata/resp_err  : one-cycle response
//   mem_addr/mem_wdata/mem_we       : RAM word index, write data, write strobe
//   mem_rdata                       : RAM read data at mem_addr
// Sub-word stores are read-modify-write: ACCESS captures the word, MERGE writes it.
module lsu
  import lsu_pkg::*;
#(
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [1:0]            req_size,
  input  logic                  req_unsigned,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [31:0]           req_wdata,
  output logic                  resp_valid,
  output logic [31:0]           resp_rdata,
  output logic                  resp_err,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [31:0]           mem_wdata,
  output logic                  mem_we,
  input  logic [31:0]           mem_rdata
);

  state_t                r_state;
  logic                  r_we;
  logic [1:0]            r_size;
  logic                  r_unsigned;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [31:0]           r_wdata;
  logic [31:0]           r_merge;
  logic                  r_resp_valid;
  logic                  r_resp_err;
  logic [31:0]           r_resp_rdata;

  logic                  w_bad;
  logic [31:0]           w_word;
  logic [31:0]           w_load;
  logic [31:0]           w_merged;

  assign w_bad = is_bad_access(r_size, r_addr[1:0]);
  // Loads read the live RAM word; the merge uses the word captured in ACCESS.
  assign w_word = (r_state == MERGE) ? r_merge : mem_rdata;

  lsu_align u_align (
    .i_size     (r_size),
    .i_unsigned (r_unsigned),
    .i_off      (r_addr[1:0]),
    .i_word     (w_word),
    .i_wdata    (r_wdata),
    .o_load     (w_load),
    .o_merged   (w_merged)
  );

  assign req_ready  = (r_state == IDLE) && !rst;
  assign resp_valid = r_resp_valid;
  assign resp_err   = r_resp_err;
  assign resp_rdata = r_resp_rdata;
  assign mem_addr   = r_addr >> 2;
  assign mem_wdata  = (r_state == MERGE) ? w_merged : r_wdata;
  // Reset gates the strobe directly so an interrupted store never writes.
  assign mem_we     = !rst &&
                      ((r_state == ACCESS && r_we && !w_bad && r_size == SIZE_W) ||
                       (r_state == MERGE));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= IDLE;
      r_we         <= 1'b0;
      r_size       <= 2'b00;
      r_unsigned   <= 1'b0;
      r_addr       <= '0;
      r_wdata      <= 32'd0;
      r_merge      <= 32'd0;
      r_resp_valid <= 1'b0;
      r_resp_err   <= 1'b0;
      r_resp_rdata <= 32'd0;
    end else begin
      r_resp_valid <= 1'b0;
      r_resp_err   <= 1'b0;
      case (r_state)
        IDLE: begin
          if (req_valid) begin
            r_we       <= req_we;
            r_size     <= req_size;
            r_unsigned <= req_unsigned;
            r_addr     <= req_addr;
            r_wdata    <= req_wdata;
            r_state    <= ACCESS;
          end
        end
        ACCESS: begin
          if (w_bad) begin
            r_resp_valid <= 1'b1;
            r_resp_err   <= 1'b1;
            r_resp_rdata <= 32'd0;
            r_state      <= IDLE;
          end else if (!r_we) begin
            r_resp_valid <= 1'b1;
            r_resp_rdata <= w_load;
            r_state      <= IDLE;
          end else if (r_size == SIZE_W) begin
            r_resp_valid <= 1'b1;
            r_resp_rdata <= 32'd0;
            r_state      <= IDLE;
          end else begin
            r_merge <= mem_rdata;
            r_state <= MERGE;
          end
        end
        MERGE: begin
          r_resp_valid <= 1'b1;
          r_resp_rdata <= 32'd0;
          r_state      <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lsu.sv
// tb_lsu: directed vector table, reset corner cases and randomized traffic
// for lsu, checked against a byte-level memory model kept in the bench.
module tb_lsu;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_we;
  logic [31:0] mem_rdata;

  int vectors = 0;
  int miscompares = 0;

  logic        tb_init;
  logic [31:0] mem     [0:63];
  logic [31:0] ref_mem [0:63];

  always #5 clk = ~clk;

  lsu #(.ADDR_WIDTH(32)) dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_we       (req_we),
    .req_size     (req_size),
    .req_unsigned (req_unsigned),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .resp_valid   (resp_valid),
    .resp_rdata   (resp_rdata),
    .resp_err     (resp_err),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .mem_we       (mem_we),
    .mem_rdata    (mem_rdata)
  );

  function automatic logic [31:0] pat(input int i);
    logic [31:0] t;
    t = i;
    if (i == 4) return 32'h8899AABB;
    return (t * 32'h9E3779B9) ^ 32'h5A5A0F0F;
  endfunction

  // RAM: combinational read, synchronous write
  assign mem_rdata = mem[mem_addr[5:0]];
  always @(posedge clk) begin
    if (tb_init) begin
      for (int i = 0; i < 64; i++) mem[i] <= pat(i);
    end else if (mem_we) begin
      mem[mem_addr[5:0]] <= mem_wdata;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: what a byte-addressed little-endian memory must do.
  function automatic void model(input logic we, input logic [1:0] size, input logic uns,
                                input logic [31:0] addr, input logic [31:0] wdata,
                                output logic [31:0] rdata, output logic err,
                                output int lat, output int wr, output logic [31:0] word);
    int nbytes, sh;
    logic [31:0] mask, old, v;
    nbytes = (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : (size == 2'd2) ? 4 : 0;
    old = ref_mem[addr[7:2]];
    sh = 8 * int'(addr % 4);
    err = (nbytes == 0) || ((addr % nbytes) != 0);
    mask = (nbytes == 4) ? 32'hFFFFFFFF : ((32'd1 << (8 * nbytes)) - 32'd1);
    rdata = 32'd0; lat = 2; wr = 0; word = old;
    if (!err) begin
      if (we) begin
        word = (old & ~(mask << sh)) | ((wdata & mask) << sh);
        wr = 1;
        lat = (nbytes == 4) ? 2 : 3;
      end else begin
        v = (old >> sh) & mask;
        if (!uns && nbytes < 4 && ((v >> (8 * nbytes - 1)) & 32'd1) == 32'd1) v = v | ~mask;
        rdata = v;
      end
    end
  endfunction

  // Called just after a falling edge; returns at the falling edge of the
  // response cycle so the next request can be accepted back-to-back.
  task automatic run_txn(input string name, input logic we, input logic [1:0] size,
                         input logic uns, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [31:0] exp_rdata, input logic exp_err, input int exp_lat,
                         input int exp_wr, input logic [31:0] exp_word);
    int lat, wr_cnt, wr_cyc;
    logic [31:0] wr_data, got_rdata;
    logic got_err, addr_bad;
    lat = 0; wr_cnt = 0; wr_cyc = 0; wr_data = 0; got_rdata = 0; got_err = 0; addr_bad = 0;
    req_valid = 1'b1; req_we = we; req_size = size; req_unsigned = uns;
    req_addr = addr; req_wdata = wdata;
    #1;
    chk({name, ".req_ready"}, {31'd0, req_ready}, 32'd1);
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      if (mem_addr !== {2'b00, addr[31:2]}) addr_bad = 1'b1;
      if (mem_we === 1'b1) begin
        wr_cnt++;
        wr_cyc = c;
        wr_data = mem_wdata;
      end
      if (resp_valid === 1'b1) begin
        lat = c;
        got_rdata = resp_rdata;
        got_err = resp_err;
        break;
      end
    end
    chk({name, ".latency"}, lat, exp_lat);
    chk({name, ".resp_err"}, {31'd0, got_err}, {31'd0, exp_err});
    chk({name, ".resp_rdata"}, got_rdata, exp_rdata);
    chk({name, ".mem_we_count"}, wr_cnt, exp_wr);
    chk({name, ".mem_addr_hold"}, {31'd0, addr_bad}, 32'd0);
    if (exp_wr != 0) begin
      chk({name, ".mem_we_cycle"}, wr_cyc, exp_lat - 1);
      chk({name, ".mem_wdata"}, wr_data, exp_word);
    end
    chk({name, ".mem_word"}, mem[addr[7:2]], exp_word);
  endtask

  typedef struct {
    string       name;
    logic        we;
    logic [1:0]  size;
    logic        uns;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        err;
    int          lat;
    int          wr;
    logic [31:0] word;
  } vec_t;

  vec_t tbl[13];

  initial begin
    logic [31:0] e_rdata, e_word, a, wd;
    logic        e_err, we, uns;
    logic [1:0]  sz;
    int          e_lat, e_wr;

    tbl[0]  = '{"lb_13",    1'b0, 2'd0, 1'b0, 32'h13, 32'h0,        32'hFFFFFF88, 1'b0, 2, 0, 32'h8899AABB};
    tbl[1]  = '{"lhu_12",   1'b0, 2'd1, 1'b1, 32'h12, 32'h0,        32'h00008899, 1'b0, 2, 0, 32'h8899AABB};
    tbl[2]  = '{"lbu_10",   1'b0, 2'd0, 1'b1, 32'h10, 32'h0,        32'h000000BB, 1'b0, 2, 0, 32'h8899AABB};
    tbl[3]  = '{"lh_10",    1'b0, 2'd1, 1'b0, 32'h10, 32'h0,        32'hFFFFAABB, 1'b0, 2, 0, 32'h8899AABB};
    tbl[4]  = '{"lw_10",    1'b0, 2'd2, 1'b0, 32'h10, 32'h0,        32'h8899AABB, 1'b0, 2, 0, 32'h8899AABB};
    tbl[5]  = '{"sh_11",    1'b1, 2'd1, 1'b0, 32'h11, 32'h0000FFFF, 32'h0,        1'b1, 2, 0, 32'h8899AABB};
    tbl[6]  = '{"ill_10",   1'b0, 2'd3, 1'b0, 32'h10, 32'h0,        32'h0,        1'b1, 2, 0, 32'h8899AABB};
    tbl[7]  = '{"lw_12",    1'b0, 2'd2, 1'b0, 32'h12, 32'h0,        32'h0,        1'b1, 2, 0, 32'h8899AABB};
    tbl[8]  = '{"sb_11",    1'b1, 2'd0, 1'b0, 32'h11, 32'h1234565A, 32'h0,        1'b0, 3, 1, 32'h88995ABB};
    tbl[9]  = '{"sh_12",    1'b1, 2'd1, 1'b0, 32'h12, 32'h0000CAFE, 32'h0,        1'b0, 3, 1, 32'hCAFE5ABB};
    tbl[10] = '{"lb_11",    1'b0, 2'd0, 1'b0, 32'h11, 32'h0,        32'h0000005A, 1'b0, 2, 0, 32'hCAFE5ABB};
    tbl[11] = '{"sw_20",    1'b1, 2'd2, 1'b0, 32'h20, 32'hDEADBEEF, 32'h0,        1'b0, 2, 1, 32'hDEADBEEF};
    tbl[12] = '{"lw_20",    1'b0, 2'd2, 1'b0, 32'h20, 32'h0,        32'hDEADBEEF, 1'b0, 2, 0, 32'hDEADBEEF};

    for (int i = 0; i < 64; i++) ref_mem[i] = pat(i);
    rst = 1'b1; tb_init = 1'b1;
    req_valid = 1'b0; req_we = 1'b0; req_size = 2'd0; req_unsigned = 1'b0;
    req_addr = 32'd0; req_wdata = 32'd0;

    @(negedge clk);
    tb_init = 1'b0;
    @(negedge clk);
    chk("rst.req_ready", {31'd0, req_ready}, 32'd0);
    chk("rst.mem_we", {31'd0, mem_we}, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("rst.resp_valid", {31'd0, resp_valid}, 32'd0);
    chk("rst.resp_err", {31'd0, resp_err}, 32'd0);
    chk("rst.resp_rdata", resp_rdata, 32'd0);
    chk("rst.mem_addr", mem_addr, 32'd0);

    // Back-to-back: each entry is issued in the previous response cycle.
    for (int i = 0; i < 13; i++) begin
      run_txn(tbl[i].name, tbl[i].we, tbl[i].size, tbl[i].uns, tbl[i].addr, tbl[i].wdata,
              tbl[i].rdata, tbl[i].err, tbl[i].lat, tbl[i].wr, tbl[i].word);
      ref_mem[tbl[i].addr[7:2]] = tbl[i].word;
    end

    // Reset during the MERGE cycle of a byte store.
    req_valid = 1'b1; req_we = 1'b1; req_size = 2'd0; req_unsigned = 1'b0;
    req_addr = 32'h10; req_wdata = 32'h000000A5;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    chk("mrst.mem_we", {31'd0, mem_we}, 32'd0);
    chk("mrst.req_ready", {31'd0, req_ready}, 32'd0);
    chk("mrst.resp_valid_in", {31'd0, resp_valid}, 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("mrst.resp_valid", {31'd0, resp_valid}, 32'd0);
    chk("mrst.resp_err", {31'd0, resp_err}, 32'd0);
    chk("mrst.resp_rdata", resp_rdata, 32'd0);
    chk("mrst.req_ready", {31'd0, req_ready}, 32'd1);
    chk("mrst.mem_we_after", {31'd0, mem_we}, 32'd0);
    chk("mrst.mem_word", mem[4], ref_mem[4]);

    // Randomized traffic against the model.
    for (int n = 0; n < 200; n++) begin
      we  = 1'($urandom_range(0, 1));
      uns = 1'($urandom_range(0, 1));
      sz  = ($urandom_range(0, 9) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
      a   = 32'($urandom_range(0, 255));
      wd  = $urandom;
      model(we, sz, uns, a, wd, e_rdata, e_err, e_lat, e_wr, e_word);
      run_txn($sformatf("rnd%0d", n), we, sz, uns, a, wd, e_rdata, e_err, e_lat, e_wr, e_word);
      ref_mem[a[7:2]] = e_word;
      if ($urandom_range(0, 3) == 0) @(negedge clk);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
